ifu_npc: RTL and testbench

- Instruction-fetch and next-PC unit for the P4 single-cycle MIPS core.
- Produces the instruction word whose OP/Func fields the controller decodes.
- Consumes the controller's NPCop/CMPop and the register-file RD1/RD2 to select the next PC.
- Fetches over a variable-latency req/ack instruction-memory port, holds each instruction for exactly one execute cycle, and supplies the PC+4 link value used by jal and bnezalc.

---
 rtl/ifu_npc.sv | 124 ++++++++++++
 tb/tb_ifu_npc.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_npc.sv
// ifu_npc: instruction fetch and next-PC selection for the P4 MIPS core.
// Fetches over a req/ack port, strobes each instruction for one cycle.
module ifu_npc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  npc_op,
  input  logic [2:0]  cmp_op,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        branch_taken,
  output logic        fetch_fault,
  output logic [31:0] retired
);

  localparam logic [31:0] IMEM_LAST =
    IMEM_BASE + 32'(IMEM_WORDS * 4) - 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] npc;
  logic [31:0] br_off;
  logic        rd1_zero;
  logic        npc_legal;
  logic        jr_misal;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign rd1_zero  = (rd1 == 32'd0);
  assign jr_misal  = (npc_op == 2'b11) && (rd1[1:0] != 2'b00);
  assign npc_legal = (npc >= IMEM_BASE) && (npc <= IMEM_LAST)
                  && (npc[1:0] == 2'b00);

  // branch comparator, signed tests use rd1 sign and zero flags
  always_comb begin
    branch_taken = 1'b0;
    case (cmp_op)
      3'b000:  branch_taken = (rd1 == rd2);
      3'b001:  branch_taken = (rd1 != rd2);
      3'b010:  branch_taken = rd1[31] | rd1_zero;
      3'b011:  branch_taken = ~rd1[31] & ~rd1_zero;
      3'b100:  branch_taken = rd1[31];
      3'b101:  branch_taken = ~rd1[31];
      3'b110:  branch_taken = ~rd1_zero;
      default: branch_taken = 1'b0;
    endcase
  end

  // next-pc select for the instruction in execute
  always_comb begin
    npc = pc_plus4;
    unique case (npc_op)
      2'b00: npc = pc_plus4;
      2'b01: npc = {pc[31:28], instr[25:0], 2'b00};
      2'b10: npc = branch_taken ? pc_plus4 + br_off : pc_plus4;
      2'b11: npc = {rd1[31:2], 2'b00};
    endcase
  end

  // fsm state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // fsm next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: state_nx = imem_ack ? S_EXEC : S_FETCH;
      S_EXEC:  state_nx = npc_legal ? S_FETCH : S_HALT;
      S_HALT:  state_nx = S_HALT;
    endcase
  end

  // fsm outputs
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (1'b1)
      (state == S_FETCH): imem_req    = 1'b1;
      (state == S_EXEC):  instr_valid = 1'b1;
      default: ;
    endcase
  end

  // instruction latch, pc update, retire count and sticky fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      retired     <= 32'd0;
      fetch_fault <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_ack) instr <= imem_rdata;
      if (state == S_EXEC) begin
        pc      <= npc;
        retired <= retired + 32'd1;
        if (jr_misal || !npc_legal) fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_npc.sv
// tb_ifu_npc: directed and randomized checks of ifu_npc.
// Expectations come from a small architectural next-pc model.
module tb_ifu_npc;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] LAST = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  npc_op = 2'b00;
  logic [2:0]  cmp_op = 3'b111;
  logic [31:0] rd1 = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic        branch_taken;
  logic        fetch_fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_fault;
  logic [31:0] e_pc;
  logic [31:0] e_npc;
  logic        e_taken;
  logic        e_legal;

  // observations from one fetch/execute
  int          o_wait;
  logic        o_held;
  logic [31:0] o_addr;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pcp4;
  logic        o_taken;
  logic        o_after_valid;
  logic [31:0] o_retired;
  logic        o_fault;
  logic        o_req;
  logic [31:0] o_pc_after;
  logic [31:0] o_instr_after;

  always #5 clk = ~clk;

  ifu_npc dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .npc_op(npc_op),
    .cmp_op(cmp_op),
    .rd1(rd1),
    .rd2(rd2),
    .branch_taken(branch_taken),
    .fetch_fault(fetch_fault),
    .retired(retired)
  );

  function automatic logic ref_taken(input logic [2:0] c,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa <= 0;
      3'd3: return sa > 0;
      3'd4: return sa < 0;
      3'd5: return sa >= 0;
      3'd6: return a != 32'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_npc(input logic [31:0] p,
                                          input logic [31:0] iw,
                                          input logic [1:0] op,
                                          input logic tk,
                                          input logic [31:0] a);
    int off;
    off = int'($signed(iw[15:0])) * 4;
    case (op)
      2'd0: return p + 32'd4;
      2'd1: return (p & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
      2'd2: return tk ? p + 32'd4 + 32'(off) : p + 32'd4;
      default: return a & 32'hFFFF_FFFC;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [31:0] n);
    return (n >= BASE) && (n <= LAST) && (n % 32'd4 == 32'd0);
  endfunction

  task automatic model_exec(input logic [31:0] iw, input logic [1:0] op,
                            input logic [2:0] cop, input logic [31:0] a,
                            input logic [31:0] b);
    e_pc    = m_pc;
    e_taken = ref_taken(cop, a, b);
    e_npc   = ref_npc(m_pc, iw, op, e_taken, a);
    e_legal = ref_legal(e_npc);
    m_ret   = m_ret + 32'd1;
    if ((op == 2'd3 && (a % 32'd4) != 32'd0) || !e_legal) m_fault = 1'b1;
    m_pc = e_npc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_pc = BASE;
    m_ret = 32'd0;
    m_fault = 1'b0;
    @(negedge clk);
  endtask

  // serve one fetch after dly wait cycles, then observe execute
  task automatic fetch_exec(input logic [31:0] iw, input logic [1:0] op,
                            input logic [2:0] cop, input logic [31:0] a,
                            input logic [31:0] b, input int dly);
    o_wait = 0;
    while (imem_req !== 1'b1 && o_wait < 20) begin
      @(negedge clk);
      o_wait++;
    end
    if (o_wait >= 20) begin
      o_wait = 99;
      o_valid = 1'b0;
      o_held = 1'b0;
      return;
    end
    o_addr = imem_addr;
    o_held = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== o_addr || instr_valid !== 1'b0)
        o_held = 1'b0;
    end
    imem_ack = 1'b1;
    imem_rdata = iw;
    npc_op = op;
    cmp_op = cop;
    rd1 = a;
    rd2 = b;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    o_valid = instr_valid;
    o_instr = instr;
    o_pc = pc;
    o_pcp4 = pc_plus4;
    o_taken = branch_taken;
    @(negedge clk);
    o_after_valid = instr_valid;
    o_retired = retired;
    o_fault = fetch_fault;
    o_req = imem_req;
    o_pc_after = pc;
    o_instr_after = instr;
  endtask

  task automatic goto_pc(input logic [31:0] t);
    model_exec(32'h0000_0008, 2'd3, 3'd7, t, 32'd0);
    fetch_exec(32'h0000_0008, 2'd3, 3'd7, t, 32'd0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== BASE || instr !== 32'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h instr=%h v=%b want 3000/0/0",
               pc, instr, instr_valid);
    end
    checks++;
    if (imem_req !== 1'b0 || fetch_fault !== 1'b0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctl req=%b fault=%b ret=%0d want 0/0/0",
               imem_req, fetch_fault, retired);
    end
    reset = 1'b1;
    m_pc = BASE;
    m_ret = 32'd0;
    m_fault = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req got %b want 0", imem_req);
    end
    @(negedge clk);
    model_exec(32'h3400_0001, 2'd0, 3'd7, 32'd0, 32'd0);
    fetch_exec(32'h3400_0001, 2'd0, 3'd7, 32'd0, 32'd0, 0);
    checks++;
    if (o_wait !== 0 || o_addr !== 32'h3000) begin
      errors++;
      $display("FAIL first_fetch wait=%0d addr=%h want 0/3000",
               o_wait, o_addr);
    end
    checks++;
    if (o_valid !== 1'b1 || o_instr !== 32'h3400_0001) begin
      errors++;
      $display("FAIL first_exec v=%b instr=%h want 1/34000001",
               o_valid, o_instr);
    end
    checks++;
    if (o_pc_after !== 32'h3004 || o_retired !== 32'd1) begin
      errors++;
      $display("FAIL first_retire pc=%h ret=%0d want 3004/1",
               o_pc_after, o_retired);
    end
  endtask

  task automatic test_ack_delay();
    model_exec(32'h2408_0007, 2'd0, 3'd7, 32'd0, 32'd0);
    fetch_exec(32'h2408_0007, 2'd0, 3'd7, 32'd0, 32'd0, 5);
    checks++;
    if (o_held !== 1'b1 || o_addr !== 32'h3004) begin
      errors++;
      $display("FAIL delay_hold held=%b addr=%h want 1/3004",
               o_held, o_addr);
    end
    checks++;
    if (o_valid !== 1'b1 || o_after_valid !== 1'b0) begin
      errors++;
      $display("FAIL delay_strobe v=%b after=%b want 1/0",
               o_valid, o_after_valid);
    end
    checks++;
    if (o_instr_after !== 32'h2408_0007 || o_retired !== 32'd2) begin
      errors++;
      $display("FAIL delay_hold_instr instr=%h ret=%0d want 24080007/2",
               o_instr_after, o_retired);
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h3010);
    model_exec(32'h1C20_FFFC, 2'd2, 3'd6, 32'd5, 32'd9);
    fetch_exec(32'h1C20_FFFC, 2'd2, 3'd6, 32'd5, 32'd9, 1);
    checks++;
    if (o_pc !== 32'h3010 || o_taken !== 1'b1) begin
      errors++;
      $display("FAIL bnez_taken pc=%h tk=%b want 3010/1", o_pc, o_taken);
    end
    checks++;
    if (o_pc_after !== 32'h3004) begin
      errors++;
      $display("FAIL bnez_target got %h want 3004", o_pc_after);
    end
    goto_pc(32'h3010);
    model_exec(32'h1C20_FFFC, 2'd2, 3'd6, 32'd0, 32'd9);
    fetch_exec(32'h1C20_FFFC, 2'd2, 3'd6, 32'd0, 32'd9, 0);
    checks++;
    if (o_taken !== 1'b0 || o_pc_after !== 32'h3014) begin
      errors++;
      $display("FAIL bnez_fall tk=%b pc=%h want 0/3014",
               o_taken, o_pc_after);
    end
  endtask

  task automatic test_jal();
    goto_pc(32'h3020);
    model_exec(32'h0C00_0C10, 2'd1, 3'd7, 32'd0, 32'd0);
    fetch_exec(32'h0C00_0C10, 2'd1, 3'd7, 32'd0, 32'd0, 2);
    checks++;
    if (o_pc !== 32'h3020 || o_pcp4 !== 32'h3024) begin
      errors++;
      $display("FAIL jal_link pc=%h p4=%h want 3020/3024", o_pc, o_pcp4);
    end
    checks++;
    if (o_pc_after !== 32'h3040 || o_fault !== 1'b0) begin
      errors++;
      $display("FAIL jal_target pc=%h fault=%b want 3040/0",
               o_pc_after, o_fault);
    end
  endtask

  task automatic test_jr_fault();
    model_exec(32'h0320_0008, 2'd3, 3'd7, 32'h3043, 32'd0);
    fetch_exec(32'h0320_0008, 2'd3, 3'd7, 32'h3043, 32'd0, 0);
    checks++;
    if (o_pc_after !== 32'h3040 || o_fault !== 1'b1 || o_req !== 1'b1) begin
      errors++;
      $display("FAIL jr_misalign pc=%h fault=%b req=%b want 3040/1/1",
               o_pc_after, o_fault, o_req);
    end
    goto_pc(LAST);
    checks++;
    if (o_pc_after !== LAST || o_req !== 1'b1) begin
      errors++;
      $display("FAIL top_legal pc=%h req=%b want 6ffc/1", o_pc_after, o_req);
    end
    model_exec(32'h2409_0001, 2'd0, 3'd7, 32'd0, 32'd0);
    fetch_exec(32'h2409_0001, 2'd0, 3'd7, 32'd0, 32'd0, 0);
    checks++;
    if (o_req !== 1'b0 || o_pc_after !== 32'h7000) begin
      errors++;
      $display("FAIL top_halt req=%b pc=%h want 0/7000", o_req, o_pc_after);
    end
  endtask

  task automatic test_halt_ignore();
    logic [31:0] keep_ret;
    logic        bad;
    keep_ret = retired;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ack = 1'b0;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || instr !== 32'h2409_0001 || retired !== keep_ret) begin
      errors++;
      $display("FAIL halt_ignore bad=%b instr=%h ret=%0d want 0/24090001/%0d",
               bad, instr, retired, keep_ret);
    end
    do_reset();
    goto_pc(32'd0);
    checks++;
    if (o_req !== 1'b0 || o_fault !== 1'b1 || o_pc_after !== 32'd0) begin
      errors++;
      $display("FAIL jr_zero req=%b fault=%b pc=%h want 0/1/0",
               o_req, o_fault, o_pc_after);
    end
    do_reset();
    goto_pc(32'hFFFF_FFFC);
    checks++;
    if (o_req !== 1'b0 || pc_plus4 !== 32'd0) begin
      errors++;
      $display("FAIL p4_wrap req=%b p4=%h want 0/0", o_req, pc_plus4);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    goto_pc(32'h3100);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== BASE) begin
      errors++;
      $display("FAIL midfetch_abort req=%b pc=%h want 0/3000", imem_req, pc);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (instr !== 32'd0 || instr_valid !== 1'b0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_ack instr=%h v=%b ret=%0d want 0/0/0",
               instr, instr_valid, retired);
    end
    reset = 1'b1;
    m_pc = BASE;
    m_ret = 32'd0;
    m_fault = 1'b0;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL late_ack instr=%h v=%b req=%b want 0/0/1",
               instr, instr_valid, imem_req);
    end
    model_exec(32'h3400_0002, 2'd0, 3'd7, 32'd0, 32'd0);
    fetch_exec(32'h3400_0002, 2'd0, 3'd7, 32'd0, 32'd0, 0);
    checks++;
    if (o_addr !== 32'h3000 || o_retired !== 32'd1) begin
      errors++;
      $display("FAIL post_reset addr=%h ret=%0d want 3000/1",
               o_addr, o_retired);
    end
  endtask

  task automatic test_random();
    logic [31:0] iw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    logic [1:0]  op;
    logic [2:0]  cop;
    logic        tk;
    int          w;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      cop = 3'($urandom_range(0, 7));
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = b;
        2: a = $urandom;
        default: a = 32'hFFFF_FFFF - $urandom_range(0, 4);
      endcase
      iw = $urandom;
      if (op == 2'd1) begin
        t = BASE + 4 * $urandom_range(0, 4095);
        iw = {6'b000011, t[27:2]};
      end else if (op == 2'd2) begin
        w = int'($urandom_range(0, 64)) - 32;
        iw = {16'h1C20, 16'(w)};
      end else if (op == 2'd3) begin
        a = BASE + 4 * $urandom_range(0, 4095);
        if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      end
      tk = ref_taken(cop, a, b);
      if (!ref_legal(ref_npc(m_pc, iw, op, tk, a))) begin
        op = 2'd3;
        a = BASE + 4 * $urandom_range(0, 4095);
      end
      model_exec(iw, op, cop, a, b);
      fetch_exec(iw, op, cop, a, b, int'($urandom_range(0, 3)));
      checks++;
      if (o_held !== 1'b1 || o_addr !== e_pc) begin
        errors++;
        $display("FAIL rnd_fetch n=%0d held=%b addr=%h want 1/%h",
                 n, o_held, o_addr, e_pc);
      end
      checks++;
      if (o_valid !== 1'b1 || o_instr !== iw || o_pc !== e_pc) begin
        errors++;
        $display("FAIL rnd_exec n=%0d v=%b instr=%h pc=%h want 1/%h/%h",
                 n, o_valid, o_instr, o_pc, iw, e_pc);
      end
      checks++;
      if (o_pcp4 !== e_pc + 32'd4) begin
        errors++;
        $display("FAIL rnd_link n=%0d got %h want %h",
                 n, o_pcp4, e_pc + 32'd4);
      end
      if (op == 2'd2) begin
        checks++;
        if (o_taken !== e_taken) begin
          errors++;
          $display("FAIL rnd_cmp n=%0d op=%0d a=%h b=%h got %b want %b",
                   n, cop, a, b, o_taken, e_taken);
        end
      end
      checks++;
      if (o_pc_after !== e_npc || o_req !== 1'b1) begin
        errors++;
        $display("FAIL rnd_npc n=%0d pc=%h req=%b want %h/1",
                 n, o_pc_after, o_req, e_npc);
      end
      checks++;
      if (o_retired !== m_ret || o_fault !== m_fault) begin
        errors++;
        $display("FAIL rnd_state n=%0d ret=%0d fault=%b want %0d/%b",
                 n, o_retired, o_fault, m_ret, m_fault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack_delay();
    test_branch();
    test_jal();
    test_jr_fault();
    test_halt_ignore();
    test_reset_midfetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
